decode_stage: RTL and testbench

Producer end of the execute-stage operand interface. It takes a fetched 16-bit instruction and its PC+2, reads the 8×16 register file and builds the extended immediate and control signals. Results land in a registered ID/EX boundary that drives `execute_stage` directly. The register-file write port is owned here and is driven by writeback.

---
 rtl/decode_stage.sv | 219 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 16-bit pipeline. Reads the 8x16 register
// file, extends the immediate, derives control signals and registers the
// result into the ID/EX boundary that feeds execute_stage.
//
// Optional feature macro: DECODE_RF_BYPASS_EN
//   defined     -> a writeback write to Rs/Rt on the same edge as the decode
//                  is forwarded into Rd1/Rd2 (write-before-read).
//   not defined -> Rd1/Rd2 capture the pre-write register contents.
module decode_stage #(
  parameter int RF_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Instr,
  input  logic [15:0] PC2_in,
  input  logic        InValid,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        WrEn,
  input  logic [2:0]  WrSel,
  input  logic [15:0] WrData,
  output logic [15:0] PC2,
  output logic [15:0] Rd1,
  output logic [15:0] Rd2,
  output logic [15:0] Imm,
  output logic [4:0]  ALUOp,
  output logic [1:0]  ALUF,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        RegWrite,
  output logic [2:0]  DstSel,
  output logic        OutValid
);

  // Immediate extension kinds.
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_S5   = 3'd1;
  localparam logic [2:0] IMM_Z5   = 3'd2;
  localparam logic [2:0] IMM_S8   = 3'd3;
  localparam logic [2:0] IMM_Z8   = 3'd4;
  localparam logic [2:0] IMM_S11  = 3'd5;

  // Instruction fields.
  logic [4:0] opcode;
  logic [2:0] rs_sel;
  logic [2:0] rt_sel;

  assign opcode = Instr[15:11];
  assign rs_sel = Instr[10:8];
  assign rt_sel = Instr[7:5];

  // ---------------------------------------------------------------------------
  // Register file. R0 is an ordinary register; every entry resets to zero.
  // ---------------------------------------------------------------------------
  logic [15:0]         rf_reg [RF_DEPTH];
  logic [RF_DEPTH-1:0] wr_hit;

  for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_wr_hit
    assign wr_hit[gi] = WrEn && (WrSel == 3'(gi));
  end

  // Writeback port: independent of Stall/Flush so retiring writes never stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        if (wr_hit[i]) begin
          rf_reg[i] <= WrData;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand read, with optional same-edge forwarding from writeback.
  // ---------------------------------------------------------------------------
  logic [15:0] rd1_next;
  logic [15:0] rd2_next;

`ifdef DECODE_RF_BYPASS_EN
  // Forward writeback data when it targets the register being read.
  always_comb begin
    rd1_next = rf_reg[rs_sel];
    rd2_next = rf_reg[rt_sel];
    if (WrEn && (WrSel == rs_sel)) begin
      rd1_next = WrData;
    end
    if (WrEn && (WrSel == rt_sel)) begin
      rd2_next = WrData;
    end
  end
`else
  // Plain read: a same-edge write is not seen until the next decode.
  always_comb begin
    rd1_next = rf_reg[rs_sel];
    rd2_next = rf_reg[rt_sel];
  end
`endif

  // ---------------------------------------------------------------------------
  // Immediate kind and control decode.
  // ---------------------------------------------------------------------------
  logic [2:0]  imm_kind;
  logic [15:0] imm_next;
  logic        alusrc_next;
  logic        branch_next;
  logic        regwrite_next;
  logic [2:0]  dstsel_next;

  // Classify the opcode by how its immediate field is extended.
  always_comb begin
    imm_kind = IMM_NONE;
    casez (opcode)
      5'b0100?, 5'b10000, 5'b10001, 5'b10011: imm_kind = IMM_S5;
      5'b0101?, 5'b101??:                     imm_kind = IMM_Z5;
      5'b011??, 5'b11000, 5'b00101, 5'b00111: imm_kind = IMM_S8;
      5'b10010:                               imm_kind = IMM_Z8;
      5'b00100, 5'b00110:                     imm_kind = IMM_S11;
      default:                                imm_kind = IMM_NONE;
    endcase
  end

  // Build the 16-bit immediate from the selected field.
  always_comb begin
    imm_next = '0;
    case (imm_kind)
      IMM_S5:  imm_next = {{11{Instr[4]}}, Instr[4:0]};
      IMM_Z5:  imm_next = {11'b0, Instr[4:0]};
      IMM_S8:  imm_next = {{8{Instr[7]}}, Instr[7:0]};
      IMM_Z8:  imm_next = {8'b0, Instr[7:0]};
      IMM_S11: imm_next = {{5{Instr[10]}}, Instr[10:0]};
      default: imm_next = '0;
    endcase
  end

  // Branches carry an immediate but compare registers, so they keep ALUSrc low.
  always_comb begin
    branch_next = (opcode[4:2] == 3'b011);
    alusrc_next = (imm_kind != IMM_NONE) && !branch_next;
  end

  // Destination register and write enable by instruction format.
  always_comb begin
    regwrite_next = 1'b0;
    dstsel_next   = 3'd0;
    casez (opcode)
      5'b11011, 5'b11010, 5'b111??: begin
        regwrite_next = 1'b1;
        dstsel_next   = Instr[4:2];
      end
      5'b010??, 5'b101??, 5'b10001: begin
        regwrite_next = 1'b1;
        dstsel_next   = Instr[7:5];
      end
      5'b11000, 5'b10010, 5'b10011: begin
        regwrite_next = 1'b1;
        dstsel_next   = Instr[10:8];
      end
      5'b00110, 5'b00111: begin
        regwrite_next = 1'b1;
        dstsel_next   = 3'd7;
      end
      default: begin
        regwrite_next = 1'b0;
        dstsel_next   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ID/EX boundary: reset > flush > stall > load. A load with InValid low
  // inserts a bubble, so OutValid always qualifies a fully decoded entry.
  // Stall holds the captured operands even if the RF changes underneath.
  // ---------------------------------------------------------------------------
  // Pipeline register update with flush/stall/load priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC2      <= '0;
      Rd1      <= '0;
      Rd2      <= '0;
      Imm      <= '0;
      ALUOp    <= '0;
      ALUF     <= '0;
      ALUSrc   <= 1'b0;
      Branch   <= 1'b0;
      RegWrite <= 1'b0;
      DstSel   <= '0;
      OutValid <= 1'b0;
    end else if (Flush || (!Stall && !InValid)) begin
      PC2      <= '0;
      Rd1      <= '0;
      Rd2      <= '0;
      Imm      <= '0;
      ALUOp    <= '0;
      ALUF     <= '0;
      ALUSrc   <= 1'b0;
      Branch   <= 1'b0;
      RegWrite <= 1'b0;
      DstSel   <= '0;
      OutValid <= 1'b0;
    end else if (!Stall) begin
      PC2      <= PC2_in;
      Rd1      <= rd1_next;
      Rd2      <= rd2_next;
      Imm      <= imm_next;
      ALUOp    <= opcode;
      ALUF     <= Instr[1:0];
      ALUSrc   <= alusrc_next;
      Branch   <= branch_next;
      RegWrite <= regwrite_next;
      DstSel   <= dstsel_next;
      OutValid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the decode stage.
// Honours DECODE_RF_BYPASS_EN the same way as the design.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [15:0] Instr;
  logic [15:0] PC2_in;
  logic        InValid;
  logic        Stall;
  logic        Flush;
  logic        WrEn;
  logic [2:0]  WrSel;
  logic [15:0] WrData;
  logic [15:0] PC2;
  logic [15:0] Rd1;
  logic [15:0] Rd2;
  logic [15:0] Imm;
  logic [4:0]  ALUOp;
  logic [1:0]  ALUF;
  logic        ALUSrc;
  logic        Branch;
  logic        RegWrite;
  logic [2:0]  DstSel;
  logic        OutValid;

  decode_stage #(.RF_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .PC2_in(PC2_in), .InValid(InValid),
    .Stall(Stall), .Flush(Flush), .WrEn(WrEn), .WrSel(WrSel), .WrData(WrData),
    .PC2(PC2), .Rd1(Rd1), .Rd2(Rd2), .Imm(Imm), .ALUOp(ALUOp), .ALUF(ALUF),
    .ALUSrc(ALUSrc), .Branch(Branch), .RegWrite(RegWrite), .DstSel(DstSel),
    .OutValid(OutValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc2;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [4:0]  op;
    logic [1:0]  f;
    logic        alusrc;
    logic        branch;
    logic        regwrite;
    logic [2:0]  dst;
    logic        valid;
  } out_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic cmp_en = 1'b0;

  out_t        exp_q;
  out_t        dut_q;
  logic [15:0] rf_m [8];

  assign dut_q = '{pc2: PC2, rd1: Rd1, rd2: Rd2, imm: Imm, op: ALUOp, f: ALUF,
                   alusrc: ALUSrc, branch: Branch, regwrite: RegWrite,
                   dst: DstSel, valid: OutValid};

  // Behavioural decode: immediate = field of given width, optionally
  // reinterpreted as a two's-complement number, reduced modulo 2^16.
  function automatic out_t decode_m(input logic [15:0] ins, input logic [15:0] pc2,
                                    input logic [15:0] a, input logic [15:0] b);
    out_t o;
    logic [4:0] op;
    int width;
    bit sgn;
    int fld;
    op = ins[15:11];
    width = 0;
    sgn = 0;
    casez (op)
      5'b0100?, 5'b10000, 5'b10001, 5'b10011: begin width = 5;  sgn = 1; end
      5'b0101?, 5'b101??:                     begin width = 5;  sgn = 0; end
      5'b011??, 5'b11000, 5'b00101, 5'b00111: begin width = 8;  sgn = 1; end
      5'b10010:                               begin width = 8;  sgn = 0; end
      5'b00100, 5'b00110:                     begin width = 11; sgn = 1; end
      default:                                begin width = 0;  sgn = 0; end
    endcase
    fld = 0;
    if (width > 0) begin
      fld = int'(ins) & ((1 << width) - 1);
      if (sgn && fld >= (1 << (width - 1))) fld = fld - (1 << width);
    end
    o = '0;
    o.pc2    = pc2;
    o.rd1    = a;
    o.rd2    = b;
    o.imm    = 16'(fld);
    o.op     = op;
    o.f      = ins[1:0];
    o.branch = (op >= 5'd12 && op <= 5'd15);
    o.alusrc = (width > 0) && !o.branch;
    casez (op)
      5'b11011, 5'b11010, 5'b111??:  begin o.regwrite = 1; o.dst = ins[4:2];  end
      5'b010??, 5'b101??, 5'b10001:  begin o.regwrite = 1; o.dst = ins[7:5];  end
      5'b11000, 5'b10010, 5'b10011:  begin o.regwrite = 1; o.dst = ins[10:8]; end
      5'b00110, 5'b00111:            begin o.regwrite = 1; o.dst = 3'd7;      end
      default:                       begin o.regwrite = 0; o.dst = 3'd0;      end
    endcase
    o.valid = 1'b1;
    return o;
  endfunction

  // Reference model: next ID/EX contents and register file state.
  always @(posedge clk or posedge rst) begin
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rs;
    logic [2:0]  rt;
    if (rst) begin
      exp_q = '0;
      for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;
    end else begin
      rs = Instr[10:8];
      rt = Instr[7:5];
      a = rf_m[rs];
      b = rf_m[rt];
`ifdef DECODE_RF_BYPASS_EN
      if (WrEn && WrSel == rs) a = WrData;
      if (WrEn && WrSel == rt) b = WrData;
`endif
      if (Flush) exp_q = '0;
      else if (!Stall) exp_q = InValid ? decode_m(Instr, PC2_in, a, b) : '0;
      if (WrEn) rf_m[WrSel] = WrData;
    end
  end

  // Per-cycle comparison of the whole ID/EX bundle against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (dut_q !== exp_q) begin
        n_fail++;
        $display("FAIL idex_bundle t=%0t actual=%h required=%h", $time, dut_q, exp_q);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end else begin
      $display("txn %s t=%0t value=%h ok", name, $time, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Instr = '0; PC2_in = '0; InValid = 1'b0; Stall = 1'b0;
    Flush = 1'b0; WrEn = 1'b0; WrSel = '0; WrData = '0;
    tick(); tick();
    chk("reset_outvalid", 16'(OutValid), 16'h0000);
    chk("reset_pc2", PC2, 16'h0000);
    chk("reset_imm", Imm, 16'h0000);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Write R1 = 1, then decode addi R1,R1,4.
    WrEn = 1'b1; WrSel = 3'd1; WrData = 16'h0001;
    tick();
    WrEn = 1'b0;
    Instr = 16'h4124; PC2_in = 16'h0002; InValid = 1'b1;
    tick();
    chk("addi_aluop", 16'(ALUOp), 16'h0008);
    chk("addi_rd1", Rd1, 16'h0001);
    chk("addi_imm", Imm, 16'h0004);
    chk("addi_alusrc", 16'(ALUSrc), 16'h0001);
    chk("addi_regwrite", 16'(RegWrite), 16'h0001);
    chk("addi_dstsel", 16'(DstSel), 16'h0001);
    chk("addi_pc2", PC2, 16'h0002);
    chk("addi_outvalid", 16'(OutValid), 16'h0001);

    Instr = 16'h481F; tick();
    chk("subi_imm", Imm, 16'hFFFF);
    Instr = 16'h581F; tick();
    chk("andni_imm", Imm, 16'h001F);
    Instr = 16'h6080; tick();
    chk("beqz_imm", Imm, 16'hFF80);
    chk("beqz_branch", 16'(Branch), 16'h0001);
    chk("beqz_alusrc", 16'(ALUSrc), 16'h0000);
    Instr = 16'h37FE; tick();
    chk("jal_imm", Imm, 16'hFFFE);
    chk("jal_dstsel", 16'(DstSel), 16'h0007);
    chk("jal_regwrite", 16'(RegWrite), 16'h0001);

    // Same-edge write of R2 while decoding a read of Rs=R2.
    Instr = 16'h4200; WrEn = 1'b1; WrSel = 3'd2; WrData = 16'hBEEF;
    tick();
    WrEn = 1'b0;
`ifdef DECODE_RF_BYPASS_EN
    chk("bypass_rd1", Rd1, 16'hBEEF);
`else
    chk("bypass_rd1", Rd1, 16'h0000);
`endif
    tick();
    chk("after_write_rd1", Rd1, 16'hBEEF);

    // Stall holds captured values while Instr and R1 change.
    Instr = 16'h4124; tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Instr = 16'($urandom); WrEn = 1'b1; WrSel = 3'd1; WrData = 16'h5555;
      tick();
      chk("stall_rd1", Rd1, 16'h0001);
      chk("stall_imm", Imm, 16'h0004);
    end
    WrEn = 1'b0;
    Flush = 1'b1; tick();
    chk("flush_outvalid", 16'(OutValid), 16'h0000);
    chk("flush_imm", Imm, 16'h0000);
    chk("flush_rd1", Rd1, 16'h0000);
    chk("flush_aluop", 16'(ALUOp), 16'h0000);
    Stall = 1'b0; Flush = 1'b0;

    // Asynchronous reset between edges while holding a valid instruction.
    Instr = 16'h4124; InValid = 1'b1; tick();
    chk("prereset_outvalid", 16'(OutValid), 16'h0001);
    chk("prereset_rd1", Rd1, 16'h5555);
    #2 rst = 1'b1;
    #1;
    chk("asyncrst_outvalid", 16'(OutValid), 16'h0000);
    chk("asyncrst_rd1", Rd1, 16'h0000);
    chk("asyncrst_pc2", PC2, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    Instr = 16'h4100;
    tick();
    chk("postrst_r1", Rd1, 16'h0000);
    chk("postrst_outvalid", 16'(OutValid), 16'h0001);

    // Randomized traffic, checked each cycle by the compare process.
    for (int i = 0; i < 1500; i++) begin
      Instr   = 16'($urandom);
      PC2_in  = 16'($urandom);
      InValid = ($urandom_range(0, 9) != 0);
      Stall   = ($urandom_range(0, 6) == 0);
      Flush   = ($urandom_range(0, 12) == 0);
      WrEn    = $urandom_range(0, 1) != 0;
      WrSel   = 3'($urandom_range(0, 7));
      WrData  = 16'($urandom);
      tick();
    end
    InValid = 1'b0; Stall = 1'b0; Flush = 1'b0; WrEn = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
